// File: rtl/pudp_encode.sv
// rtl/pudp_encode.sv - PUDP transmit packetizer: 4x64-bit AXI-Stream channels in, framed 8-bit stream out.
// Frame is [type][payload bytes][xor checksum]; channels granted round-robin per packet.
module pudp_encode (
  input  logic             clki,
  input  logic             rsti,
  input  logic [3:0]       s_axis_tvalid,
  output logic [3:0]       s_axis_tready,
  input  logic [3:0]       s_axis_tlast,
  input  logic [3:0][7:0]  s_axis_tkeep,
  input  logic [3:0][63:0] s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tdata
);

  typedef enum logic [1:0] {IDLE, TYPE, DATA, CSUM} state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant, grant_nxt, rr_ptr, cand;
  logic [7:0]  chk;
  logic        pkt_end;
  logic [63:0] buf_data;
  logic [7:0]  buf_keep;
  logic [2:0]  lane;
  logic [7:0]  cur_byte;
  logic        buf_empty, last_byte, m_hs, rdy, load, end_now;

  // buf_keep holds only the lanes still waiting to be sent; lowest set lane goes next
  always_comb begin
    lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (buf_keep[i]) lane = 3'(i);
    end
  end

  assign cur_byte  = buf_data[{lane, 3'b000} +: 8];
  assign buf_empty = (buf_keep == 8'h00);
  assign last_byte = !buf_empty && ((buf_keep & (buf_keep - 8'd1)) == 8'h00);

  always_comb begin
    grant_nxt = rr_ptr;
    cand      = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (s_axis_tvalid[cand]) grant_nxt = cand;
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 8'h00;
    case (state)
      TYPE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {6'b0, grant};
      end
      DATA: begin
        m_axis_tvalid = !buf_empty;
        m_axis_tdata  = cur_byte;
      end
      CSUM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = chk;
      end
      default: ;
    endcase
  end

  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign rdy  = ((state == TYPE) || (state == DATA)) && !pkt_end &&
                (buf_empty || ((state == DATA) && m_hs && last_byte));
  assign s_axis_tready = rdy ? (4'b0001 << grant) : 4'b0000;
  assign load    = rdy && s_axis_tvalid[grant];
  // an empty tlast beat arriving now ends the packet without a stall cycle
  assign end_now = load && s_axis_tlast[grant] && (s_axis_tkeep[grant] == 8'h00);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|s_axis_tvalid) state_nxt = TYPE;
      TYPE: if (m_hs) state_nxt = (pkt_end || end_now) ? CSUM : DATA;
      DATA: begin
        if (pkt_end && buf_empty)
          state_nxt = CSUM;
        else if (m_hs && last_byte && (pkt_end || end_now))
          state_nxt = CSUM;
      end
      CSUM: if (m_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clki or posedge rsti) begin
    if (rsti) begin
      state    <= IDLE;
      grant    <= 2'd0;
      rr_ptr   <= 2'd0;
      chk      <= 8'h00;
      pkt_end  <= 1'b0;
      buf_data <= 64'h0;
      buf_keep <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|s_axis_tvalid) begin
          grant <= grant_nxt;
          chk   <= {6'b0, grant_nxt};
        end
        DATA: if (m_hs) begin
          chk            <= chk ^ cur_byte;
          buf_keep[lane] <= 1'b0;
        end
        CSUM: if (m_hs) begin
          rr_ptr  <= grant + 2'd1;
          chk     <= 8'h00;
          pkt_end <= 1'b0;
        end
        default: ;
      endcase
      if (load) begin
        buf_data <= s_axis_tdata[grant];
        buf_keep <= s_axis_tkeep[grant];
        pkt_end  <= s_axis_tlast[grant];
      end
    end
  end

endmodule

// File: tb/tb_pudp_encode.sv
// tb/tb_pudp_encode.sv - scoreboard bench for pudp_encode.
module tb_pudp_encode;

  logic             clki = 1'b0;
  logic             rsti = 1'b1;
  logic [3:0]       s_axis_tvalid = '0;
  logic [3:0]       s_axis_tready;
  logic [3:0]       s_axis_tlast = '0;
  logic [3:0][7:0]  s_axis_tkeep = '0;
  logic [3:0][63:0] s_axis_tdata = '0;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             m_axis_tlast;
  logic [7:0]       m_axis_tdata;

  pudp_encode dut (
    .clki          (clki),
    .rsti          (rsti),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata)
  );

  always #5 clki = ~clki;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  beat_t src_q[4][$];
  exp_t  exp_q[$];
  int    span_q[$];
  int    gap_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clki) cyc <= cyc + 1;

  // source beats and m_axis_tready change only 1ns after the rising edge
  initial begin
    logic [3:0] hs_s;
    forever begin
      @(negedge clki);
      hs_s = s_axis_tvalid & s_axis_tready;
      @(posedge clki);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (hs_s[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      end
      if (ready_mode == 0) m_axis_tready = 1'b1;
      else m_axis_tready = ~m_axis_tready;
      for (int c = 0; c < 4; c++) begin
        if (src_q[c].size() > 0) begin
          s_axis_tvalid[c] = 1'b1;
          s_axis_tdata[c]  = src_q[c][0].data;
          s_axis_tkeep[c]  = src_q[c][0].keep;
          s_axis_tlast[c]  = src_q[c][0].last;
        end else begin
          s_axis_tvalid[c] = 1'b0;
          s_axis_tdata[c]  = 64'h0;
          s_axis_tkeep[c]  = 8'h00;
          s_axis_tlast[c]  = 1'b0;
        end
      end
    end
  end

  initial begin
    bit in_frame = 1'b0;
    int first_cyc = 0;
    int prev_end = -100;
    exp_t e;
    forever begin
      @(negedge clki);
      if (rsti) begin
        in_frame = 1'b0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          first_cyc = cyc;
          gap_q.push_back(cyc - prev_end);
        end
        if (exp_q.size() == 0) begin
          check_val("unexpected_byte", {56'h0, m_axis_tdata}, 64'h1ff);
        end else begin
          e = exp_q.pop_front();
          check_val("byte", {56'h0, m_axis_tdata}, {56'h0, e.data});
          check_val("tlast", {63'h0, m_axis_tlast}, {63'h0, e.last});
        end
        if (m_axis_tlast) begin
          in_frame = 1'b0;
          prev_end = cyc;
          span_q.push_back(cyc - first_cyc + 1);
        end
      end else if (m_axis_tvalid && !m_axis_tready && exp_q.size() > 0) begin
        check_val("stall_byte", {56'h0, m_axis_tdata}, {56'h0, exp_q[0].data});
        check_val("stall_tlast", {63'h0, m_axis_tlast}, {63'h0, exp_q[0].last});
      end
    end
  end

  task automatic push_pkt(input int ch, input int nb,
                          input logic [63:0] d0, input logic [7:0] k0,
                          input logic [63:0] d1, input logic [7:0] k1);
    logic [7:0]  sum;
    logic [63:0] d;
    logic [7:0]  k;
    sum = 8'(ch);
    exp_q.push_back('{data: 8'(ch), last: 1'b0});
    for (int b = 0; b < nb; b++) begin
      d = (b == 0) ? d0 : d1;
      k = (b == 0) ? k0 : k1;
      src_q[ch].push_back('{data: d, keep: k, last: (b == nb - 1)});
      for (int l = 0; l < 8; l++) begin
        if (k[l]) begin
          exp_q.push_back('{data: d[l*8 +: 8], last: 1'b0});
          sum = sum ^ d[l*8 +: 8];
        end
      end
    end
    exp_q.push_back('{data: sum, last: 1'b1});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clki);
      n++;
    end
    check_val("drain", 64'(exp_q.size()), 64'h0);
    repeat (3) @(posedge clki);
    #2;
  endtask

  task automatic clear_meas();
    span_q.delete();
    gap_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clki);
    #2;
    check_val("rst_m_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    check_val("rst_m_tlast", {63'h0, m_axis_tlast}, 64'h0);
    check_val("rst_m_tdata", {56'h0, m_axis_tdata}, 64'h0);
    check_val("rst_s_tready", {60'h0, s_axis_tready}, 64'h0);
    rsti = 1'b0;
    repeat (2) @(posedge clki);
    #2;

    // ch2, single full beat
    clear_meas();
    push_pkt(2, 1, 64'h0807060504030201, 8'hFF, 64'h0, 8'h00);
    check_val("s1_chk_model", {56'h0, exp_q[9].data}, 64'h0A);
    wait_drain(200);
    check_val("s1_span", 64'(span_q.size() > 0 ? span_q[0] : -1), 64'd10);

    // ch0, two beats, second partially kept
    clear_meas();
    push_pkt(0, 2, 64'h1817161514131211, 8'hFF, 64'h0000000000232221, 8'h07);
    wait_drain(200);
    check_val("s2_span", 64'(span_q.size() > 0 ? span_q[0] : -1), 64'd13);

    // ch3, empty packet
    clear_meas();
    push_pkt(3, 1, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0, 8'h00);
    check_val("s5_len", 64'(exp_q.size()), 64'd2);
    wait_drain(200);

    // all four channels at once, ch0 re-requested while ch3 is being served
    clear_meas();
    for (int c = 0; c < 4; c++) push_pkt(c, 1, 64'(8'h40 + c), 8'h01, 64'h0, 8'h00);
    begin
      int n = 0;
      while (span_q.size() < 3 && n < 200) begin
        @(negedge clki);
        n++;
      end
      #1;
    end
    push_pkt(0, 1, 64'h0000000000000055, 8'h01, 64'h0, 8'h00);
    wait_drain(300);
    check_val("s4_frames", 64'(span_q.size()), 64'd5);
    for (int f = 1; f < 5; f++) begin
      check_val($sformatf("s4_gap%0d", f), 64'(gap_q.size() > f ? gap_q[f] : -1), 64'd2);
      check_val($sformatf("s4_span%0d", f), 64'(span_q.size() > f ? span_q[f] : -1), 64'd3);
    end

    // scenario 1 again under alternating backpressure
    clear_meas();
    ready_mode = 1;
    push_pkt(2, 1, 64'h0807060504030201, 8'hFF, 64'h0, 8'h00);
    wait_drain(300);
    ready_mode = 0;
    repeat (2) @(posedge clki);
    #2;

    // reset in the middle of the ch0 two-beat payload
    clear_meas();
    push_pkt(0, 2, 64'h1817161514131211, 8'hFF, 64'h0000000000232221, 8'h07);
    begin
      int n = 0;
      while (exp_q.size() > 8 && n < 200) begin
        @(posedge clki);
        n++;
      end
      check_val("s6_reach_data", 64'(exp_q.size()), 64'd8);
    end
    #3;
    rsti = 1'b1;
    for (int c = 0; c < 4; c++) src_q[c].delete();
    exp_q.delete();
    #1;
    check_val("s6_m_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
    check_val("s6_s_tready", {60'h0, s_axis_tready}, 64'h0);
    check_val("s6_m_tdata", {56'h0, m_axis_tdata}, 64'h0);
    repeat (3) @(posedge clki);
    #3;
    rsti = 1'b0;
    clear_meas();
    push_pkt(1, 1, 64'h0000000000006261, 8'h03, 64'h0, 8'h00);
    push_pkt(3, 1, 64'h0000000000000071, 8'h01, 64'h0, 8'h00);
    wait_drain(300);
    check_val("s6_frames", 64'(span_q.size()), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
